xnor_popcount_stream: RTL and testbench

Streaming, parametrised XNOR-popcount engine for binarised-network neurons. It accepts a weight/activation vector as one or more WIDTH-bit beats and accumulates the XNOR popcount across the beats. On the last beat it emits either the raw count or the bipolar dot product, together with a threshold-compare activation bit. It replaces the fixed-width, handshake-less popcount trees: it adds a valid/ready flow, multi-beat folding, a bipolar mode and overflow reporting.

---
 rtl/xnor_popcount_stream.sv | 123 ++++++++++++
 tb/tb_xnor_popcount_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_popcount_stream.sv
// Streaming XNOR-popcount neuron: folds multi-beat vectors into a raw count or bipolar dot product.
// Latency 2 cycles from last beat to out_valid; out_valid & ~out_ready freezes the whole pipe and drops in_ready.
module xnor_popcount_stream #(
    parameter  int WIDTH     = 128,
    parameter  int MAX_BEATS = 8,
    parameter  int BIPOLAR   = 1,
    localparam int ACC_W     = $clog2(MAX_BEATS*WIDTH+1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [WIDTH-1:0]        xi,
    input  logic [WIDTH-1:0]        wi,
    input  logic signed [ACC_W:0]   threshold,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W:0]   out_sum,
    output logic                    out_bit,
    output logic                    out_ovf
);

    localparam int PW = $clog2(WIDTH) + 1;
    localparam int BW = $clog2(MAX_BEATS) + 1;
    localparam int LW = $clog2(WIDTH);
    localparam int SW = ACC_W + 1;

    logic                  stall;
    logic [WIDTH-1:0]      xnor_v;
    logic [PW-1:0]         pop_c;

    logic                  s1_vld;
    logic                  s1_last;
    logic [PW-1:0]         s1_pop;
    logic signed [SW-1:0]  s1_thr;

    logic [ACC_W-1:0]      acc;
    logic [BW-1:0]         beats;
    logic                  ovf;

    logic                  keep;
    logic [ACC_W-1:0]      p_sum;
    logic [BW-1:0]         b_sum;
    logic                  ovf_nxt;
    logic [SW-1:0]         bip;
    logic signed [SW-1:0]  res_sum;
    logic                  res_bit;
    logic                  res_load;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign xnor_v   = ~(xi ^ wi);

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_c = pop_c + PW'(xnor_v[i]);
        end
    end

    // While not stalled in_ready is 1, so every presented beat is an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_pop  <= '0;
            s1_thr  <= '0;
        end else if (!stall) begin
            s1_vld  <= in_valid;
            s1_last <= in_last;
            s1_pop  <= pop_c;
            s1_thr  <= threshold;
        end
    end

    // Beats past MAX_BEATS contribute nothing but flag the vector as overflowed.
    always_comb begin
        keep     = (beats < BW'(MAX_BEATS));
        p_sum    = acc + (keep ? ACC_W'(s1_pop) : '0);
        b_sum    = beats + (keep ? BW'(1) : '0);
        ovf_nxt  = ovf | ~keep;
        bip      = {p_sum, 1'b0} - (SW'(b_sum) << LW);
        res_sum  = (BIPOLAR != 0) ? $signed(bip) : $signed(SW'(p_sum));
        res_bit  = (res_sum >= s1_thr);
        res_load = s1_vld & s1_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            beats <= '0;
            ovf   <= 1'b0;
        end else if (!stall && s1_vld) begin
            if (s1_last) begin
                acc   <= '0;
                beats <= '0;
                ovf   <= 1'b0;
            end else begin
                acc   <= p_sum;
                beats <= b_sum;
                ovf   <= ovf_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_bit   <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= res_load;
            if (res_load) begin
                out_sum <= res_sum;
                out_bit <= res_bit;
                out_ovf <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_xnor_popcount_stream.sv
// Scoreboard bench: bipolar and raw instances share stimulus; a behavioural model predicts every result.
module tb_xnor_popcount_stream;

    localparam int W  = 128;
    localparam int MB = 4;
    localparam int AW = $clog2(MB*W+1);
    localparam int SW = AW + 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid, in_last, out_ready;
    logic [W-1:0]          xi, wi;
    logic signed [SW-1:0]  threshold;
    logic                  in_ready_b, out_valid_b, out_bit_b, out_ovf_b;
    logic                  in_ready_r, out_valid_r, out_bit_r, out_ovf_r;
    logic signed [SW-1:0]  out_sum_b, out_sum_r;

    always #5 clk = ~clk;

    xnor_popcount_stream #(.WIDTH(W), .MAX_BEATS(MB), .BIPOLAR(1)) u_bip (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_last(in_last), .xi(xi), .wi(wi), .threshold(threshold),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
        .out_bit(out_bit_b), .out_ovf(out_ovf_b));

    xnor_popcount_stream #(.WIDTH(W), .MAX_BEATS(MB), .BIPOLAR(0)) u_raw (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_last(in_last), .xi(xi), .wi(wi), .threshold(threshold),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_sum(out_sum_r),
        .out_bit(out_bit_r), .out_ovf(out_ovf_r));

    typedef struct {
        int sb; int sr; bit bb; bit br; bit ov; int cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   rmode = 0;
    int   bp_lo = 0;
    bit   chk_lat = 1'b1;
    bit   accepted;
    bit   hold_pend = 1'b0;
    int   hold_sb, hold_sr;
    bit   hold_bb, hold_ov;
    int   m_acc = 0, m_beats = 0;
    bit   m_ovf = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_beat();
        exp_t e;
        int   p;
        p = $countones(~(xi ^ wi));
        if (m_beats < MB) begin
            m_acc += p;
            m_beats++;
        end else begin
            m_ovf = 1'b1;
        end
        if (in_last) begin
            e.sb  = 2*m_acc - m_beats*W;
            e.sr  = m_acc;
            e.bb  = (e.sb >= int'(threshold));
            e.br  = (e.sr >= int'(threshold));
            e.ov  = m_ovf;
            e.cyc = cyc;
            q.push_back(e);
            m_acc = 0; m_beats = 0; m_ovf = 1'b0;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        exp_t e;
        bit   exp_rdy;
        cyc++;
        exp_rdy = !(cyc >= bp_lo && cyc < bp_lo + 3);
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 4) != 0);
            default: out_ready = exp_rdy;
        endcase
        #1;
        if (hold_pend) begin
            check("hold_sum_b", out_sum_b, hold_sb);
            check("hold_sum_r", out_sum_r, hold_sr);
            check("hold_bit_b", out_bit_b, hold_bb);
            check("hold_ovf_b", out_ovf_b, hold_ov);
        end
        hold_pend = out_valid_b && !out_ready;
        hold_sb = out_sum_b; hold_sr = out_sum_r; hold_bb = out_bit_b; hold_ov = out_ovf_b;
        if (rmode == 2) begin
            check("bp_in_ready_b", in_ready_b, exp_rdy);
            check("bp_in_ready_r", in_ready_r, exp_rdy);
        end
        if (out_valid_b && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_result", 1, 0);
            end else begin
                e = q.pop_front();
                check("valid_r", out_valid_r, 1);
                check("sum_bip", out_sum_b, e.sb);
                check("sum_raw", out_sum_r, e.sr);
                check("bit_bip", out_bit_b, e.bb);
                check("bit_raw", out_bit_r, e.br);
                check("ovf_bip", out_ovf_b, e.ov);
                check("ovf_raw", out_ovf_r, e.ov);
                if (chk_lat) check("latency", cyc - e.cyc, 2);
            end
        end
        accepted = in_valid && in_ready_b;
        if (accepted) model_beat();
        @(negedge clk);
    endtask

    // mode 0: xi == wi, mode 1: xi == ~wi, otherwise independent random bits.
    task automatic send_vec(input int n, input int mode, input int thr, input int cut);
        for (int b = 0; b < cut; b++) begin
            wi = {$urandom, $urandom, $urandom, $urandom};
            case (mode)
                0:       xi = wi;
                1:       xi = ~wi;
                default: xi = {$urandom, $urandom, $urandom, $urandom};
            endcase
            in_valid  = 1'b1;
            in_last   = (b == n - 1);
            threshold = in_last ? SW'(thr) : SW'($urandom);
            accepted  = 1'b0;
            for (int t = 0; t < 200 && !accepted; t++) tick();
            if (!accepted) check("accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic override(input int sb, input int sr, input bit bb, input bit br, input bit ov);
        exp_t e;
        e = q.pop_back();
        e.sb = sb; e.sr = sr; e.bb = bb; e.br = br; e.ov = ov;
        q.push_back(e);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && q.size() > 0; i++) tick();
        tick();
        tick();
        check("drain_empty", q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid_b"}, out_valid_b, 0);
        check({tag, "_sum_b"},   out_sum_b,   0);
        check({tag, "_bit_b"},   out_bit_b,   0);
        check({tag, "_ovf_b"},   out_ovf_b,   0);
        check({tag, "_valid_r"}, out_valid_r, 0);
        check({tag, "_sum_r"},   out_sum_r,   0);
        check({tag, "_in_ready"}, in_ready_b, 1);
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_mid");
        q.delete();
        m_acc = 0; m_beats = 0; m_ovf = 1'b0;
        hold_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        xi = '0; wi = '0; threshold = '0;
        #3;
        check_zero_outputs("rst_init");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-beat equal inputs, including threshold exactly at and just above the sum.
        rmode = 0; chk_lat = 1'b1;
        send_vec(1, 0, 0, 1);    override(128, 128, 1, 1, 0);
        send_vec(1, 0, 128, 1);  override(128, 128, 1, 1, 0);
        send_vec(1, 0, 129, 1);  override(128, 128, 0, 0, 0);
        drain();

        send_vec(3, 1, -384, 3); override(-384, 0, 1, 1, 0);
        send_vec(3, 1, 1, 3);    override(-384, 0, 0, 0, 0);
        drain();

        // Overflow past MAX_BEATS, then a clean vector, then exactly MAX_BEATS beats.
        send_vec(6, 0, 0, 6);    override(512, 512, 1, 1, 1);
        send_vec(1, 0, 200, 1);  override(128, 128, 0, 0, 0);
        send_vec(MB, 0, 512, MB); override(512, 512, 1, 1, 0);
        send_vec(5, 1, 0, 5);    override(-512, 0, 0, 1, 1);
        drain();

        chk_lat = 1'b0; rmode = 2; bp_lo = cyc + 6;
        for (int v = 0; v < 12; v++) send_vec(1, 2, int'($urandom_range(0, 256)) - 128, 1);
        drain();

        rmode = 0; chk_lat = 1'b1;
        send_vec(4, 0, 0, 2);
        mid_reset();
        send_vec(1, 0, 0, 1);    override(128, 128, 1, 1, 0);
        drain();

        chk_lat = 1'b0; rmode = 1;
        for (int v = 0; v < 10000; v++) begin
            send_vec(int'($urandom_range(1, MB + 2)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 1400)) - 700, MB + 2);
            if ($urandom_range(0, 15) == 0) tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
